// File: rtl/adc_pkg.sv
// Shared types and frame constants for the dual-channel ADC sampler.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} adc_state_t;

  localparam int NBITS      = 17;
  localparam int DATA_FIRST = 5;

  localparam logic MOSI_START = 1'b1;
  localparam logic MOSI_SGL   = 1'b1;
  localparam logic MOSI_MSBF  = 1'b1;

  // Command bit driven on mosi for frame bit b; ch selects the input channel.
  function automatic logic mosi_bit(input logic [4:0] b, input logic ch);
    case (b)
      5'd0:    return MOSI_START;
      5'd1:    return MOSI_SGL;
      5'd2:    return ch;
      5'd3:    return MOSI_MSBF;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// SPI mode-0 bit clock: sclk low then high for SCLK_DIV clks each, with edge strobes and bit index.
module spi_bit_timer #(
  parameter int SCLK_DIV = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       sclk,
  output logic       rise,
  output logic       fall,
  output logic [4:0] bit_idx
);

  localparam logic [7:0] DIV_M1 = 8'(SCLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       strike;

  // rise/fall mark the clk edge on which sclk toggles
  assign strike = run && (div_cnt == DIV_M1);
  assign rise   = strike && !sclk;
  assign fall   = strike && sclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_idx <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_idx <= '0;
    end else if (strike) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      if (sclk) bit_idx <= bit_idx + 5'd1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_dual_sampler.sv
// SPI master alternately converting both channels of an MCP3202-style ADC.
// Define ADC_AVG_EN to present a 4-sample running average instead of raw samples.
module adc_dual_sampler
  import adc_pkg::*;
#(
  parameter int SCLK_DIV = 24,
  parameter int CS_IDLE  = 48,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] p1data,
  output logic [DATA_W-1:0] p2data,
  output logic              sample_valid
);

  localparam logic [7:0] IDLE_M1    = 8'(CS_IDLE - 1);
  localparam logic [4:0] LAST_BIT   = 5'(NBITS - 1);
  localparam logic [4:0] FIRST_DATA = 5'(DATA_FIRST);

  adc_state_t        state_q, state_d;
  logic [7:0]        idle_cnt;
  logic              idle_done;
  logic              ch;
  logic              rise, fall;
  logic [4:0]        bit_idx;
  logic [DATA_W-1:0] shreg;

  spi_bit_timer #(.SCLK_DIV(SCLK_DIV)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == SHIFT),
    .sclk    (sclk),
    .rise    (rise),
    .fall    (fall),
    .bit_idx (bit_idx)
  );

  // Idle counter saturates, so a late enable starts the next frame at once.
  assign idle_done = (idle_cnt == IDLE_M1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (idle_done && enable) state_d = SHIFT;
      SHIFT:   if (fall && (bit_idx == LAST_BIT)) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idle_cnt <= '0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_cnt <= (state_q != IDLE) ? 8'd0 : (idle_done ? idle_cnt : idle_cnt + 8'd1);
      if (state_q == IDLE && state_d == SHIFT) begin
        cs_n <= 1'b0;
        mosi <= mosi_bit(5'd0, ch);
      end else if (state_q == SHIFT && fall) begin
        if (bit_idx == LAST_BIT) begin
          cs_n <= 1'b1;
          mosi <= 1'b0;
        end else begin
          mosi <= mosi_bit(bit_idx + 5'd1, ch);
        end
      end
    end
  end

  // Capture: data bits arrive MSB first after the null bit
  always_ff @(posedge clk) begin
    if (state_q == IDLE) shreg <= '0;
    else if (state_q == SHIFT && rise && bit_idx >= FIRST_DATA)
      shreg <= {shreg[DATA_W-2:0], miso};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch           <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state_q == LATCH) && ch;
      if (state_q == LATCH) ch <= ~ch;
    end
  end

`ifdef ADC_AVG_EN
  localparam int SW = DATA_W + 2;

  logic [SW-1:0]     sum1, sum2;
  logic [DATA_W-1:0] hist1 [4];
  logic [DATA_W-1:0] hist2 [4];

  // Output: running sum of the last four samples, divided by four
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum1 <= '0;
      sum2 <= '0;
      for (int i = 0; i < 4; i++) begin
        hist1[i] <= '0;
        hist2[i] <= '0;
      end
    end else if (state_q == LATCH) begin
      if (!ch) begin
        sum1     <= sum1 + SW'(shreg) - SW'(hist1[3]);
        for (int i = 3; i > 0; i--) hist1[i] <= hist1[i-1];
        hist1[0] <= shreg;
      end else begin
        sum2     <= sum2 + SW'(shreg) - SW'(hist2[3]);
        for (int i = 3; i > 0; i--) hist2[i] <= hist2[i-1];
        hist2[0] <= shreg;
      end
    end
  end

  assign p1data = sum1[SW-1:2];
  assign p2data = sum2[SW-1:2];
`else
  logic [DATA_W-1:0] raw1, raw2;

  // Output: latest raw sample per channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw1 <= '0;
      raw2 <= '0;
    end else if (state_q == LATCH) begin
      if (!ch) raw1 <= shreg;
      else     raw2 <= shreg;
    end
  end

  assign p1data = raw1;
  assign p2data = raw2;
`endif

endmodule

// File: tb/tb_adc_dual_sampler.sv
// Scoreboard bench for adc_dual_sampler with a behavioural MCP3202-style ADC.
module tb_adc_dual_sampler;

  logic        clk = 1'b0;
  logic        reset, enable, miso;
  logic        sclk, cs_n, mosi, sample_valid;
  logic [11:0] p1data, p2data;

  adc_dual_sampler #(.SCLK_DIV(2), .CS_IDLE(4), .DATA_W(12)) dut (
    .clk (clk), .reset (reset), .enable (enable), .miso (miso),
    .sclk (sclk), .cs_n (cs_n), .mosi (mosi),
    .p1data (p1data), .p2data (p2data), .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC model: answers with the value of the channel requested on mosi bit 2
  logic [11:0] adc_val [2];
  logic        pre_fill;
  logic        adc_ch = 1'b0;
  logic        m_prev_cs = 1'b1;
  logic        m_prev_sclk = 1'b0;
  logic [11:0] m_tmp;
  int          rk = 0;

  always @(cs_n or sclk) begin
    if (!cs_n) begin
      if (m_prev_cs) begin
        rk   = 0;
        miso = pre_fill;
      end else if (sclk && !m_prev_sclk) begin
        if (rk == 2) adc_ch = mosi;
        rk++;
      end else if (!sclk && m_prev_sclk && rk <= 16) begin
        m_tmp = adc_val[adc_ch];
        miso  = (rk < 5) ? pre_fill : m_tmp[16-rk];
      end
    end
    m_prev_cs   = cs_n;
    m_prev_sclk = sclk;
  end

  // Scoreboard
  typedef struct packed {logic ch; logic [11:0] raw;} exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic        prev_cs, prev_sclk;
  int          low_cnt, rise_cnt, frames_done = 0;
  logic [16:0] mosi_cap;
  bit          active, pending, post;
  logic        exp_ch, last_b2;
  logic [11:0] exp_p1, exp_p2;
`ifdef ADC_AVG_EN
  logic [11:0] h1 [4];
  logic [11:0] h2 [4];

  function automatic logic [11:0] avg4(input logic [11:0] a, b, c, d);
    logic [13:0] s;
    s = 14'(a) + 14'(b) + 14'(c) + 14'(d);
    return s[13:2];
  endfunction
`endif

  always @(negedge clk) begin
    if (reset) begin
      active = 0; pending = 0; post = 0;
      sbq.delete();
      exp_ch = 1'b0; exp_p1 = '0; exp_p2 = '0;
`ifdef ADC_AVG_EN
      for (int i = 0; i < 4; i++) begin h1[i] = '0; h2[i] = '0; end
`endif
    end else begin
      if (post) begin
        chk_eq("sv_single_clk", sample_valid, 0);
        post = 0;
      end
      if (pending) begin
        pending = 0;
        if (sbq.size() == 0) chk_eq("sb_underflow", 0, 1);
        else begin
          mon_e = sbq.pop_front();
`ifdef ADC_AVG_EN
          if (!mon_e.ch) begin
            h1[3] = h1[2]; h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = mon_e.raw;
            exp_p1 = avg4(h1[0], h1[1], h1[2], h1[3]);
          end else begin
            h2[3] = h2[2]; h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = mon_e.raw;
            exp_p2 = avg4(h2[0], h2[1], h2[2], h2[3]);
          end
`else
          if (!mon_e.ch) exp_p1 = mon_e.raw;
          else           exp_p2 = mon_e.raw;
`endif
          chk_eq("p1data", p1data, exp_p1);
          chk_eq("p2data", p2data, exp_p2);
          chk_eq("sample_valid", sample_valid, mon_e.ch);
          post   = 1;
          exp_ch = ~exp_ch;
          frames_done++;
        end
      end
      if (!cs_n && prev_cs) begin
        active = 1; low_cnt = 0; rise_cnt = 0; mosi_cap = '0;
        mon_e.ch = exp_ch; mon_e.raw = adc_val[exp_ch];
        sbq.push_back(mon_e);
      end
      if (active) begin
        if (!cs_n) begin
          low_cnt++;
          if (sclk && !prev_sclk) begin
            if (rise_cnt < 17) mosi_cap[rise_cnt] = mosi;
            rise_cnt++;
          end
        end else begin
          chk_eq("cs_low_clks", low_cnt, 68);
          chk_eq("sclk_rises", rise_cnt, 17);
          chk_eq("mosi_bits", mosi_cap, {13'd0, 1'b1, exp_ch, 2'b11});
          last_b2 = mosi_cap[2];
          active  = 0;
          pending = 1;
        end
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  task automatic wait_frame_start(input logic want_ch);
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk); #1;
      if (active && low_cnt == 1 && exp_ch == want_ch) ok = 1;
    end
    chk_eq("frame_start_seen", ok, 1);
  endtask

  task automatic wait_rises(input int n);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= n) ok = 1;
    end
    chk_eq("rises_seen", ok, 1);
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    bit ok = 0;
    for (int i = 0; i < n * 100 + 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (frames_done >= target) ok = 1;
    end
    chk_eq("frames_done", ok, 1);
  endtask

  task automatic set_pattern(input logic pre, input logic [11:0] v0, input logic [11:0] v1);
    enable = 0;
    repeat (90) @(negedge clk);
    pre_fill = pre; adc_val[0] = v0; adc_val[1] = v1;
    enable = 1;
    wait_frames(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset = 1; enable = 1; miso = 0; pre_fill = 0;
    adc_val[0] = 12'h0E1; adc_val[1] = 12'h8CC;
    repeat (2) @(posedge clk); #1;
    chk_eq("rst_cs_n", cs_n, 1);
    chk_eq("rst_sclk", sclk, 0);
    chk_eq("rst_mosi", mosi, 0);
    chk_eq("rst_p1", p1data, 0);
    chk_eq("rst_p2", p2data, 0);
    chk_eq("rst_sv", sample_valid, 0);
    @(negedge clk); reset = 0;

    // first ch0 result lands 4+69 clks after release, ch1 one period later
    repeat (72) @(posedge clk); #1;
    chk_eq("p1_before_73", p1data, 0);
    @(posedge clk); #1;
    chk_eq("p1_at_73", p1data != 0, 1);
    repeat (72) @(posedge clk); #1;
    chk_eq("p2_before_146", p2data, 0);
    chk_eq("sv_before_146", sample_valid, 0);
    @(posedge clk); #1;
    chk_eq("p2_at_146", p2data != 0, 1);
    chk_eq("sv_at_146", sample_valid, 1);

    // enable dropped mid ch0 frame
    wait_frame_start(1'b0);
    wait_rises(9);
    enable = 0;
    wait_frames(1);
    f0 = frames_done;
    repeat (150) @(negedge clk); #1;
    chk_eq("idle_cs_n", cs_n, 1);
    chk_eq("idle_no_frame", frames_done, f0);
    chk_eq("hold_p1", p1data, exp_p1);
    chk_eq("hold_p2", p2data, exp_p2);
    enable = 1;
    wait_frames(1);
    chk_eq("resume_b2_ch1", last_b2, 1);

    // reset in the middle of a ch1 frame
    wait_frame_start(1'b1);
    wait_rises(11);
    @(posedge clk); #2;
    reset = 1; #1;
    chk_eq("mid_rst_cs_n", cs_n, 1);
    chk_eq("mid_rst_sclk", sclk, 0);
    chk_eq("mid_rst_p1", p1data, 0);
    chk_eq("mid_rst_p2", p2data, 0);
    repeat (2) @(negedge clk); reset = 0;
    wait_frames(1);
    chk_eq("post_rst_b2_ch0", last_b2, 0);

    // data boundaries
    set_pattern(1'b1, 12'hFFF, 12'hFFF);
    set_pattern(1'b0, 12'h000, 12'h000);
    set_pattern(1'b1, 12'h000, 12'h000);
    set_pattern(1'b0, 12'hA5A, 12'h5A5);

`ifdef ADC_AVG_EN
    @(posedge clk); #2;
    reset = 1;
    pre_fill = 0; adc_val[0] = 12'd400; adc_val[1] = 12'd0;
    repeat (2) @(negedge clk); reset = 0;
    wait_frames(8);
    chk_eq("avg_p1_400", p1data, 12'd400);
    set_pattern(1'b0, 12'd800, 12'd0);
    chk_eq("avg_p1_500", p1data, 12'd500);
`endif

    enable = 0;
    repeat (100) @(negedge clk); #1;
    chk_eq("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
